// File: rtl/scope_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scope_pkg
//  Purpose  : Shared screen/sample defaults, coordinate width, trace-writer
//             state encoding and small coordinate helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package scope_pkg;

  localparam int c_SCREEN_WIDTH_DEF  = 640;
  localparam int c_SCREEN_HEIGHT_DEF = 480;
  localparam int c_SAMPLE_WIDTH_DEF  = 8;

  // Framebuffer coordinates are always 10 bits wide.
  localparam int c_COORD_W = 10;

  typedef logic [c_COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CLEAR_REQ   = 3'd1,
    ST_CLEAR_WAIT  = 3'd2,
    ST_WAIT_SAMPLE = 3'd3,
    ST_DRAW        = 3'd4,
    ST_DONE        = 3'd5
  } state_e;

  function automatic coord_t coord_min(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t coord_max(input coord_t a, input coord_t b);
    return (a < b) ? b : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_row_map.sv
`default_nettype none
// ============================================================================
//  Module   : trace_row_map
//  Purpose  : Combinational sample-to-row mapping. Sample 0 maps to the
//             bottom row; full scale approaches the top row.
//  Revision : 1.0 - initial release
// ============================================================================
module trace_row_map
  import scope_pkg::*;
#(
  parameter int SCREEN_HEIGHT = c_SCREEN_HEIGHT_DEF,
  parameter int SAMPLE_WIDTH  = c_SAMPLE_WIDTH_DEF
) (
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  output logic [c_COORD_W-1:0]    row_o
);

  // Product width large enough that sample*height never overflows.
  localparam int c_PROD_W = SAMPLE_WIDTH + $clog2(SCREEN_HEIGHT + 1);

  localparam logic [c_PROD_W-1:0] c_HEIGHT  = c_PROD_W'(SCREEN_HEIGHT);
  localparam logic [c_PROD_W-1:0] c_ROW_MAX = c_PROD_W'(SCREEN_HEIGHT - 1);

  logic [c_PROD_W-1:0] w_prod;
  logic [c_PROD_W-1:0] w_scaled;
  logic [c_PROD_W-1:0] w_row;

  // Scale at full width, flip so larger samples sit higher on screen, then trim.
  always_comb begin
    w_prod   = c_PROD_W'(sample_i) * c_HEIGHT;
    w_scaled = w_prod >> SAMPLE_WIDTH;
    w_row    = c_ROW_MAX - w_scaled;
    row_o    = c_COORD_W'(w_row);
  end

endmodule
`default_nettype wire

// File: rtl/trace_writer.sv
`default_nettype none
// ============================================================================
//  Module   : trace_writer
//  Purpose  : Sweeps one frame of an oscilloscope trace into a 1-bit
//             framebuffer: clear, then per column accept one sample and draw
//             a vertical segment joining it to the previous column's row.
//  Revision : 1.0 - initial release
// ============================================================================
module trace_writer
  import scope_pkg::*;
#(
  parameter int SCREEN_WIDTH  = c_SCREEN_WIDTH_DEF,
  parameter int SCREEN_HEIGHT = c_SCREEN_HEIGHT_DEF,
  parameter int SAMPLE_WIDTH  = c_SAMPLE_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    trig,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_ready,
  output logic [c_COORD_W-1:0]    write_h,
  output logic [c_COORD_W-1:0]    write_v,
  output logic                    write_data,
  output logic                    wren,
  output logic                    clear,
  input  logic                    clear_done,
  output logic                    busy,
  output logic                    frame_done
);

  localparam coord_t c_H_LAST = c_COORD_W'(SCREEN_WIDTH - 1);

  state_e state_q, state_d;
  coord_t h_q, h_d;             // current column
  coord_t y_prev_q, y_prev_d;   // row of the most recently accepted sample
  coord_t y_end_q, y_end_d;     // last (highest-numbered) row of the segment
  coord_t write_h_q, write_h_d;
  coord_t write_v_q, write_v_d; // doubles as the segment row counter

  coord_t w_y_cur;
  coord_t w_y_from;
  coord_t w_y_lo;
  coord_t w_y_hi;

  trace_row_map #(
    .SCREEN_HEIGHT (SCREEN_HEIGHT),
    .SAMPLE_WIDTH  (SAMPLE_WIDTH)
  ) u_row_map (
    .sample_i (sample_data),
    .row_o    (w_y_cur)
  );

  // The first column of a frame has no predecessor, so it draws a single point.
  assign w_y_from = (h_q == '0) ? w_y_cur : y_prev_q;
  assign w_y_lo   = coord_min(w_y_from, w_y_cur);
  assign w_y_hi   = coord_max(w_y_from, w_y_cur);

  // Sequencing: next state plus column/segment bookkeeping.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    y_prev_d  = y_prev_q;
    y_end_d   = y_end_q;
    write_h_d = write_h_q;
    write_v_d = write_v_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_CLEAR_REQ;
        end
      end
      ST_CLEAR_REQ: begin
        state_d = ST_CLEAR_WAIT;
      end
      ST_CLEAR_WAIT: begin
        if (clear_done) begin
          h_d     = '0;
          state_d = ST_WAIT_SAMPLE;
        end
      end
      ST_WAIT_SAMPLE: begin
        if (sample_valid) begin
          // Load the segment so its first pixel is presented next cycle.
          y_prev_d  = w_y_cur;
          y_end_d   = w_y_hi;
          write_h_d = h_q;
          write_v_d = w_y_lo;
          state_d   = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (write_v_q == y_end_q) begin
          if (h_q == c_H_LAST) begin
            state_d = ST_DONE;
          end else begin
            h_d     = h_q + 10'd1;
            state_d = ST_WAIT_SAMPLE;
          end
        end else begin
          write_v_d = write_v_q + 10'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      y_prev_q  <= '0;
      y_end_q   <= '0;
      write_h_q <= '0;
      write_v_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      y_prev_q  <= y_prev_d;
      y_end_q   <= y_end_d;
      write_h_q <= write_h_d;
      write_v_q <= write_v_d;
    end
  end

  // Status and strobes decode straight from the state register, so they
  // follow an asynchronous reset in the same cycle.
  assign sample_ready = (state_q == ST_WAIT_SAMPLE);
  assign wren         = (state_q == ST_DRAW);
  assign clear        = (state_q == ST_CLEAR_REQ);
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = (state_q == ST_DONE);
  assign write_data   = 1'b1;
  assign write_h      = write_h_q;
  assign write_v      = write_v_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_writer
//  Purpose  : Self-checking bench for trace_writer against a behavioural
//             pixel-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trace_writer;

  localparam int W = 640;
  localparam int H = 480;
  localparam int S = 8;

  // Phases of a sweep as seen from the outside.
  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_CWAIT = 2;
  localparam int P_WAIT  = 3;
  localparam int P_DRAW  = 4;
  localparam int P_DONE  = 5;

  logic       clk;
  logic       rst_n;
  logic       trig;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       sample_ready;
  logic [9:0] write_h;
  logic [9:0] write_v;
  logic       write_data;
  logic       wren;
  logic       clear;
  logic       clear_done;
  logic       busy;
  logic       frame_done;

  trace_writer #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .SAMPLE_WIDTH  (S)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trig         (trig),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .write_h      (write_h),
    .write_v      (write_v),
    .write_data   (write_data),
    .wren         (wren),
    .clear        (clear),
    .clear_done   (clear_done),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_phase;
  int m_col;
  int m_last_y;
  int m_pix[$];          // rows still to be written for the current column
  int m_hold_h;
  int m_hold_v;
  int n_wren_obs = 0;
  int n_fd_obs   = 0;
  int walk       = 128;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int row_of(input int d);
    return (H - 1) - ((d * H) >> S);
  endfunction

  function automatic int next_walk(input int base);
    int v;
    if ($urandom_range(0, 31) == 0) return int'($urandom_range(0, 255));
    v = base + int'($urandom_range(0, 16)) - 8;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_col    = 0;
    m_last_y = 0;
    m_pix.delete();
    m_hold_h = 0;
    m_hold_v = 0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_advance();
    int y, yp, lo, hi;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE:  if (trig) m_phase = P_CLEAR;
      P_CLEAR: m_phase = P_CWAIT;
      P_CWAIT: if (clear_done) begin m_phase = P_WAIT; m_col = 0; end
      P_WAIT: begin
        if (sample_valid) begin
          y  = row_of(int'(sample_data));
          yp = (m_col == 0) ? y : m_last_y;
          lo = (y < yp) ? y : yp;
          hi = (y < yp) ? yp : y;
          for (int v = lo; v <= hi; v++) m_pix.push_back(v);
          m_last_y = y;
          m_phase  = P_DRAW;
        end
      end
      P_DRAW: begin
        m_hold_h = m_col;
        m_hold_v = m_pix.pop_front();
        if (m_pix.size() == 0) begin
          if (m_col == W - 1) m_phase = P_DONE;
          else begin m_col++; m_phase = P_WAIT; end
        end
      end
      P_DONE:  m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic compare_outputs();
    logic [5:0]  exp_ctl;
    logic [19:0] exp_pix;
    exp_ctl = {m_phase == P_CLEAR, m_phase == P_WAIT, m_phase == P_DRAW,
               m_phase != P_IDLE, m_phase == P_DONE, 1'b1};
    check_eq("ctl{clear,ready,wren,busy,done,data}",
             {26'd0, clear, sample_ready, wren, busy, frame_done, write_data}, {26'd0, exp_ctl});
    if (m_phase == P_DRAW) exp_pix = {10'(m_col), 10'(m_pix[0])};
    else                   exp_pix = {10'(m_hold_h), 10'(m_hold_v)};
    check_eq("pix{h,v}", {12'd0, write_h, write_v}, {12'd0, exp_pix});
    if (wren) n_wren_obs++;
    if (frame_done) n_fd_obs++;
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  // Present one sample in WAIT and let its segment drain; returns pixel count.
  task automatic feed_sample(input int d, input bit trig_in_draw, output int writes);
    int start, cnt;
    start        = n_wren_obs;
    sample_valid = 1'b1;
    sample_data  = 8'(d);
    tick();
    sample_valid = 1'b0;
    cnt = 0;
    while (m_phase == P_DRAW && cnt < 1000) begin
      trig = trig_in_draw && (cnt == 3);
      tick();
      cnt++;
    end
    trig = 1'b0;
    writes = n_wren_obs - start;
  endtask

  // Randomised driving until the sweep ends (or reaches stop_col while drawing).
  task automatic drive_sweep(input int kind, input int stop_col, input int budget);
    int cnt;
    cnt = 0;
    while (m_phase != P_IDLE) begin
      if (stop_col >= 0 && m_phase == P_DRAW && m_col == stop_col) break;
      if (cnt >= budget) begin
        check_eq("sweep_budget_busy", {31'd0, busy}, 32'd0);
        break;
      end
      trig         = ($urandom_range(0, 15) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      clear_done   = (m_phase == P_CWAIT) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 1) == 0);
      if (m_phase == P_WAIT) begin
        sample_data = (kind == 0) ? 8'd128 : 8'(next_walk(walk));
        if (sample_valid) walk = int'(sample_data);
      end else begin
        sample_data = 8'($urandom_range(0, 255));
      end
      tick();
      cnt++;
    end
    trig         = 1'b0;
    sample_valid = 1'b0;
    clear_done   = 1'b0;
  endtask

  task automatic start_frame();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr, fd0, wr0, cnt;
    rst_n        = 1'b0;
    trig         = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'd0;
    clear_done   = 1'b0;
    model_reset();
    repeat (3) tick();
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Clear handshake with clear_done five cycles after the clear pulse
    start_frame();
    check_eq("clear_pulse", {31'd0, clear}, 32'd1);
    repeat (5) tick();
    check_eq("ready_before_cdone", {31'd0, sample_ready}, 32'd0);
    clear_done = 1'b1;
    tick();
    clear_done = 1'b0;
    check_eq("ready_after_cdone", {31'd0, sample_ready}, 32'd1);

    // Samples 0, 255, 128 on the first three columns
    feed_sample(0, 1'b0, wr);
    check_eq("col0_writes", wr, 32'd1);
    feed_sample(255, 1'b0, wr);
    check_eq("col1_writes", wr, 32'd479);
    feed_sample(128, 1'b0, wr);
    check_eq("col2_writes", wr, 32'd239);

    // Stall 20 cycles with no valid sample, then trig while drawing
    wr0 = n_wren_obs;
    repeat (20) tick();
    check_eq("stall_no_wren", n_wren_obs - wr0, 32'd0);
    check_eq("stall_hold_h", {22'd0, write_h}, 32'd2);
    feed_sample(0, 1'b1, wr);
    check_eq("col3_writes", wr, 32'd241);

    // Random walk to column 300, then reset mid-segment
    drive_sweep(1, 300, 20000);
    check_eq("at_col300_wren", {31'd0, wren}, 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    check_eq("async_reset_vh", {12'd0, write_h, write_v}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wr0 = n_wren_obs;
    cnt = 0;
    repeat (10) begin
      sample_valid = 1'b1;
      clear_done   = 1'b1;
      sample_data  = 8'($urandom_range(0, 255));
      tick();
      cnt++;
    end
    sample_valid = 1'b0;
    clear_done   = 1'b0;
    check_eq("post_reset_no_wren", n_wren_obs - wr0, 32'd0);
    check_eq("post_reset_idle", {31'd0, busy}, 32'd0);

    // Full frame of constant mid-scale samples
    fd0 = n_fd_obs;
    wr0 = n_wren_obs;
    start_frame();
    drive_sweep(0, -1, 20000);
    check_eq("flat_frame_writes", n_wren_obs - wr0, 32'd640);
    check_eq("flat_frame_done", n_fd_obs - fd0, 32'd1);
    check_eq("flat_frame_lastv", {22'd0, write_v}, 32'd239);
    check_eq("flat_frame_idle", {31'd0, busy}, 32'd0);
    repeat (3) tick();

    // Full frame of random-walk samples
    fd0  = n_fd_obs;
    walk = 128;
    start_frame();
    drive_sweep(1, -1, 60000);
    check_eq("walk_frame_done", n_fd_obs - fd0, 32'd1);
    check_eq("walk_frame_idle", {31'd0, busy}, 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_writer.md
TRACE_WRITER -- requirements
Module: trace_writer

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640, SHALL be the number of columns swept per frame.
REQ-002 Parameter SCREEN_HEIGHT, default 480, SHALL be the number of rows; row 0 is the top of the screen.
REQ-003 Parameter SAMPLE_WIDTH, default 8, SHALL be the width of the unsigned ADC sample.
REQ-004 clk  in  1  SHALL be the sole clock; all logic is posedge clk.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 trig  in  1  SHALL be a one-cycle sweep start request, sampled only in IDLE.
REQ-007 sample_valid  in  1  SHALL flag sample_data as valid.
REQ-008 sample_data  in  SAMPLE_WIDTH  SHALL be the unsigned sample value.
REQ-009 sample_ready  out  1  SHALL be high only in WAIT_SAMPLE; a sample is accepted on a cycle where valid and ready are both high.
REQ-010 write_h  out  10  SHALL be the framebuffer column address.
REQ-011 write_v  out  10  SHALL be the framebuffer row address.
REQ-012 write_data  out  1  SHALL be constant 1 (trace colour).
REQ-013 wren  out  1  SHALL be the framebuffer write strobe, one pixel per cycle.
REQ-014 clear  out  1  SHALL be the framebuffer clear request.
REQ-015 clear_done  in  1  SHALL be the framebuffer clear-complete flag.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.
REQ-017 frame_done  out  1  SHALL pulse for one cycle when a sweep completes.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR_REQ, CLEAR_WAIT, WAIT_SAMPLE, DRAW, DONE.
REQ-019 IDLE -> CLEAR_REQ on trig; trig in any other state SHALL be ignored.
REQ-020 CLEAR_REQ SHALL drive clear=1 for exactly one cycle, then go to CLEAR_WAIT.
REQ-021 CLEAR_WAIT SHALL hold clear=0 and go to WAIT_SAMPLE on the first cycle clear_done=1, with column counter h=0.
REQ-022 On sample acceptance, row y_cur SHALL be (SCREEN_HEIGHT-1) - ((sample_data*SCREEN_HEIGHT) >> SAMPLE_WIDTH), computed at full width before truncation to 10 bits; FSM -> DRAW.
REQ-023 For h=0 y_prev SHALL equal y_cur; otherwise y_prev SHALL be the y_cur of column h-1.
REQ-024 DRAW SHALL write, one per cycle with wren=1, write_h=h, rows min(y_prev,y_cur) to max(y_prev,y_cur) inclusive, ascending; |y_cur-y_prev|+1 cycles.
REQ-025 After the last pixel of a column: if h=SCREEN_WIDTH-1 -> DONE, else h increments and FSM -> WAIT_SAMPLE.
REQ-026 DONE SHALL assert frame_done for one cycle and return to IDLE.
REQ-027 wren SHALL be 0 outside DRAW; write_h/write_v SHALL hold their last value when wren=0.
REQ-028 Sample latency: first pixel of a column SHALL appear the cycle after acceptance.
REQ-029 clear and wren SHALL never be high in the same cycle.

Reset
REQ-030 On rst_n low, FSM SHALL enter IDLE asynchronously; wren, clear, sample_ready, busy, frame_done, write_h, write_v, h, y_prev SHALL be 0; write_data SHALL be 1.
REQ-031 Reset mid-sweep SHALL abandon the frame with no further writes; the next sweep requires a new trig.

Structure
REQ-032 SCREEN_WIDTH, SCREEN_HEIGHT, SAMPLE_WIDTH defaults and the state encoding SHALL live in shared package scope_pkg.
REQ-033 The sample-to-row mapping of REQ-022 SHALL be a combinational sub-module trace_row_map.

Verification
REQ-034 trig, clear_done raised 5 cycles after clear -> clear pulse 1 cycle, sample_ready rises the cycle after clear_done.
REQ-035 Samples 0,255,128 at h=0,1,2 -> rows 479; 1..479 at h=1 (479 writes); 1..239 at h=2 (239 writes).
REQ-036 640 identical samples of 128 -> exactly one write per column at row 239, frame_done one pulse after h=639, then IDLE.
REQ-037 sample_valid held low 20 cycles in WAIT_SAMPLE -> no wren, state and h unchanged; trig during DRAW -> ignored.
REQ-038 rst_n low during DRAW at h=300 -> all outputs reset values same cycle, no wren after release until new trig and clear_done.
